// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: runs the host request-to-send sequence
// (inhibit, start, 8 data bits LSB first, odd parity, stop, device ACK)
// over the open-drain PS/2 clock/data pair. Both lines are released
// whenever the FSM is idle, including immediately on reset.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 6000,
    parameter int unsigned TIMEOUT_CYCLES = 750000
) (
    input  logic       fpgaclk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_ack,
    output logic       tx_err,
    input  logic       ps2clk_in,
    input  logic       ps2dat_in,
    output logic       ps2clk_oe,
    output logic       ps2dat_oe
);

    localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_START,
        S_SEND,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_idx_q, bit_idx_d;
    logic [9:0]    frame_q, frame_d;     // {parity, data[7:0], start}
    logic          ack_cap_q, ack_cap_d;
    logic          done_q, done_d;
    logic          tx_ack_q, tx_ack_d;
    logic          tx_err_q, tx_err_d;

    logic clk_s1_q, clk_s2_q, clk_prev_q;
    logic dat_s1_q, dat_s2_q;
    logic clk_fall;
    logic timed_out;
    logic clk_oe, dat_oe;

    // Two-flop synchronizers on both pins plus a delayed copy of the clock for edge detection
    always_ff @(posedge fpgaclk or negedge rst) begin
        if (!rst) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
        end else begin
            clk_s1_q   <= ps2clk_in;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            dat_s1_q   <= ps2dat_in;
            dat_s2_q   <= dat_s1_q;
        end
    end

    assign clk_fall  = clk_prev_q & ~clk_s2_q;
    assign timed_out = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    // FSM and datapath state registers
    always_ff @(posedge fpgaclk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            frame_q   <= '0;
            ack_cap_q <= 1'b0;
            done_q    <= 1'b0;
            tx_ack_q  <= 1'b0;
            tx_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            frame_q   <= frame_d;
            ack_cap_q <= ack_cap_d;
            done_q    <= done_d;
            tx_ack_q  <= tx_ack_d;
            tx_err_q  <= tx_err_d;
        end
    end

    // Next-state, counter and line-drive logic; the one counter serves as inhibit timer and edge timeout
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        frame_d   = frame_q;
        ack_cap_d = ack_cap_q;
        done_d    = 1'b0;
        tx_ack_d  = tx_ack_q;
        tx_err_d  = tx_err_q;
        clk_oe    = 1'b0;
        dat_oe    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // A request coinciding with the completion pulse is dropped
                if (tx_start && !done_q) begin
                    frame_d  = {~^tx_data, tx_data, 1'b0};
                    cnt_d    = '0;
                    tx_ack_d = 1'b0;
                    tx_err_d = 1'b0;
                    state_d  = S_INHIBIT;
                end
            end

            S_INHIBIT: begin
                clk_oe = 1'b1;
                if (cnt_q == CW'(INHIBIT_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = S_START;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_START: begin
                clk_oe    = 1'b1;
                dat_oe    = 1'b1;
                bit_idx_d = '0;
                cnt_d     = '0;
                state_d   = S_SEND;
            end

            S_SEND: begin
                // Index 0 is the start bit; the stop bit (released line) is what ACK drives
                dat_oe = ~frame_q[bit_idx_q];
                if (clk_fall) begin
                    cnt_d = '0;
                    if (bit_idx_q == 4'd9) begin
                        state_d = S_ACK;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else if (timed_out) begin
                    cnt_d    = '0;
                    done_d   = 1'b1;
                    tx_ack_d = 1'b0;
                    tx_err_d = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_ACK: begin
                if (clk_fall) begin
                    cnt_d     = '0;
                    ack_cap_d = ~dat_s2_q;
                    state_d   = S_WAIT_IDLE;
                end else if (timed_out) begin
                    cnt_d    = '0;
                    done_d   = 1'b1;
                    tx_ack_d = 1'b0;
                    tx_err_d = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_WAIT_IDLE: begin
                if (clk_s2_q && dat_s2_q) begin
                    cnt_d    = '0;
                    done_d   = 1'b1;
                    tx_ack_d = ack_cap_q;
                    tx_err_d = 1'b0;
                    state_d  = S_IDLE;
                end else if (clk_fall) begin
                    cnt_d = '0;
                end else if (timed_out) begin
                    cnt_d    = '0;
                    done_d   = 1'b1;
                    tx_ack_d = 1'b0;
                    tx_err_d = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ps2clk_oe = clk_oe;
    assign ps2dat_oe = dat_oe;
    assign tx_busy   = (state_q != S_IDLE);
    assign tx_done   = done_q;
    assign tx_ack    = tx_ack_q;
    assign tx_err    = tx_err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: an open-drain device model clocks
// frames out of the host and compares captured bits against a frame model.
module tb_ps2_host_tx;

    localparam int INH = 50;
    localparam int TMO = 1000;

    logic       fpgaclk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] tx_data = '0;
    logic       tx_start = 1'b0;
    logic       tx_busy, tx_done, tx_ack, tx_err;
    logic       ps2clk_in, ps2dat_in, ps2clk_oe, ps2dat_oe;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;

    int vectors = 0;
    int miscompares = 0;

    // Wired-AND open-drain bus: either side may pull a line low
    assign ps2clk_in = dev_clk & ~ps2clk_oe;
    assign ps2dat_in = dev_dat & ~ps2dat_oe;

    always #5 fpgaclk = ~fpgaclk;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .fpgaclk  (fpgaclk),
        .rst      (rst),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
        .tx_ack   (tx_ack),
        .tx_err   (tx_err),
        .ps2clk_in(ps2clk_in),
        .ps2dat_in(ps2dat_in),
        .ps2clk_oe(ps2clk_oe),
        .ps2dat_oe(ps2dat_oe)
    );

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1);
    end

    // Reference model: the 11 bits a device should see, in wire order
    function automatic logic [10:0] exp_frame(input logic [7:0] d);
        logic [10:0] f;
        int ones;
        ones = 0;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            f[i + 1] = ((d >> i) & 8'd1) != 0;
            ones += ((d >> i) & 8'd1);
        end
        f[9]  = (ones % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic send_req(input logic [7:0] d, output logic busy_next);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge fpgaclk);
        tx_start  = 1'b0;
        tx_data   = 8'($urandom_range(0, 255));
        busy_next = tx_busy;
    endtask

    // Device side: measures the inhibit phase, then clocks n_edges falling edges
    task automatic device_frame(input logic ack_low, input int n_edges,
                                output logic [10:0] got, output int inh_len,
                                output int overlap, output bit ok);
        int half;
        half = $urandom_range(30, 50);
        got = '0;
        inh_len = 0;
        overlap = 0;
        ok = 1'b1;
        for (int n = 0; n < 200 && !ps2clk_oe; n++) @(negedge fpgaclk);
        for (int n = 0; n < 20000 && ps2clk_oe; n++) begin
            inh_len++;
            if (ps2dat_oe) overlap++;
            @(negedge fpgaclk);
        end
        if (ps2clk_oe || inh_len == 0) ok = 1'b0;
        for (int k = 0; k < n_edges; k++) begin
            repeat (half) @(negedge fpgaclk);
            got[k] = ps2dat_in;
            if (k == 10) begin
                dev_dat = ~ack_low;
                repeat (5) @(negedge fpgaclk);
            end
            dev_clk = 1'b0;
            repeat (half) @(negedge fpgaclk);
            if (k == n_edges - 1 && n_edges < 11) return;
            dev_clk = 1'b1;
        end
        dev_dat = 1'b1;
    endtask

    task automatic wait_done(output bit seen, output logic ack, output logic err,
                             output logic busy, output logic cloe, output logic dtoe);
        seen = 1'b0;
        ack = 1'bx; err = 1'bx; busy = 1'bx; cloe = 1'bx; dtoe = 1'bx;
        for (int n = 0; n < 3000 && !seen; n++) begin
            @(negedge fpgaclk);
            if (tx_done) begin
                seen = 1'b1;
                ack  = tx_ack;
                err  = tx_err;
                busy = tx_busy;
                cloe = ps2clk_oe;
                dtoe = ps2dat_oe;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(negedge fpgaclk);
        vectors++;
        if ({tx_busy, tx_done, tx_ack, tx_err, ps2clk_oe, ps2dat_oe} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b expected 000000",
                     {tx_busy, tx_done, tx_ack, tx_err, ps2clk_oe, ps2dat_oe});
        end
        rst = 1'b1;
        repeat (5) @(negedge fpgaclk);
        vectors++;
        if ({tx_busy, tx_done, ps2clk_oe, ps2dat_oe} !== 4'b0) begin
            miscompares++;
            $display("FAIL post_reset_idle: got %b expected 0000",
                     {tx_busy, tx_done, ps2clk_oe, ps2dat_oe});
        end
    endtask

    // Full frames: fixed bytes (0xED, parity corners) then random bytes with random ACK/NACK
    task automatic test_frames(input int n_random);
        logic [7:0] bytes[$];
        logic [7:0] d;
        logic ack_low, busy_next, ack, err, busy, cloe, dtoe;
        logic [10:0] got;
        int inh_len, overlap;
        bit ok, seen;
        bytes = '{8'hED, 8'h00, 8'h01, 8'hFF};
        for (int i = 0; i < n_random; i++) bytes.push_back(8'($urandom_range(0, 255)));
        foreach (bytes[i]) begin
            d = bytes[i];
            ack_low = (i < 4) ? 1'b1 : 1'($urandom_range(0, 1));
            send_req(d, busy_next);
            device_frame(ack_low, 11, got, inh_len, overlap, ok);
            wait_done(seen, ack, err, busy, cloe, dtoe);
            vectors++;
            if (busy_next !== 1'b1) begin
                miscompares++;
                $display("FAIL busy_after_start[%02h]: got %b expected 1", d, busy_next);
            end
            vectors++;
            if (!ok || inh_len != INH + 1 || overlap != 1) begin
                miscompares++;
                $display("FAIL inhibit[%02h]: ok=%0d clk_oe_cycles=%0d both_oe_cycles=%0d expected 1/%0d/1",
                         d, ok, inh_len, overlap, INH + 1);
            end
            vectors++;
            if (got !== exp_frame(d)) begin
                miscompares++;
                $display("FAIL frame_bits[%02h]: got %b expected %b", d, got, exp_frame(d));
            end
            vectors++;
            if (!seen || ack !== ack_low || err !== 1'b0 || busy !== 1'b0 || cloe !== 1'b0 || dtoe !== 1'b0) begin
                miscompares++;
                $display("FAIL done_status[%02h]: seen=%0d ack=%b err=%b busy=%b oe=%b%b expected 1/%b/0/0/00",
                         d, seen, ack, err, busy, cloe, dtoe, ack_low);
            end
            @(negedge fpgaclk);
            vectors++;
            if (tx_done !== 1'b0 || tx_ack !== ack_low || tx_err !== 1'b0) begin
                miscompares++;
                $display("FAIL status_hold[%02h]: done=%b ack=%b err=%b expected 0/%b/0",
                         d, tx_done, tx_ack, tx_err, ack_low);
            end
            repeat (10) @(negedge fpgaclk);
        end
    endtask

    task automatic test_busy_ignore;
        logic busy_next, ack, err, busy, cloe, dtoe;
        logic [10:0] got;
        int inh_len, overlap, activity;
        bit ok, seen;
        send_req(8'hED, busy_next);
        fork
            device_frame(1'b1, 11, got, inh_len, overlap, ok);
            begin
                repeat (20) @(negedge fpgaclk);
                tx_data  = 8'hF4;
                tx_start = 1'b1;
                @(negedge fpgaclk);
                tx_start = 1'b0;
                repeat (200) @(negedge fpgaclk);
                tx_data  = 8'hF4;
                tx_start = 1'b1;
                @(negedge fpgaclk);
                tx_start = 1'b0;
            end
        join
        wait_done(seen, ack, err, busy, cloe, dtoe);
        vectors++;
        if (got !== exp_frame(8'hED) || !ok) begin
            miscompares++;
            $display("FAIL busy_ignore_bits: got %b expected %b", got, exp_frame(8'hED));
        end
        vectors++;
        if (!seen || ack !== 1'b1 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_ignore_done: seen=%0d ack=%b err=%b expected 1/1/0", seen, ack, err);
        end
        activity = 0;
        for (int n = 0; n < 300; n++) begin
            @(negedge fpgaclk);
            if (ps2clk_oe || tx_busy) activity++;
        end
        vectors++;
        if (activity != 0) begin
            miscompares++;
            $display("FAIL busy_ignore_no_second_frame: active cycles %0d expected 0", activity);
        end
    endtask

    task automatic test_start_on_done;
        logic busy_next;
        logic [10:0] got;
        int inh_len, overlap, activity;
        bit ok, seen;
        send_req(8'hA5, busy_next);
        device_frame(1'b1, 11, got, inh_len, overlap, ok);
        seen = 1'b0;
        for (int n = 0; n < 3000 && !seen; n++) begin
            @(negedge fpgaclk);
            if (tx_done) seen = 1'b1;
        end
        tx_data  = 8'h3C;
        tx_start = 1'b1;
        @(negedge fpgaclk);
        tx_start = 1'b0;
        activity = 0;
        for (int n = 0; n < 100; n++) begin
            if (tx_busy || ps2clk_oe) activity++;
            @(negedge fpgaclk);
        end
        vectors++;
        if (!seen || activity != 0) begin
            miscompares++;
            $display("FAIL start_on_done_ignored: seen=%0d active cycles %0d expected 1/0", seen, activity);
        end
    endtask

    task automatic test_timeout;
        logic busy_next;
        int k;
        bit seen;
        send_req(8'h5A, busy_next);
        for (int n = 0; n < 200 && ps2clk_oe; n++) @(negedge fpgaclk);
        k = 0;
        seen = 1'b0;
        for (int n = 0; n < 3000 && !seen; n++) begin
            @(negedge fpgaclk);
            k++;
            if (tx_done) seen = 1'b1;
        end
        vectors++;
        if (!seen || k != TMO) begin
            miscompares++;
            $display("FAIL timeout_latency: seen=%0d cycles=%0d expected %0d", seen, k, TMO);
        end
        vectors++;
        if (tx_err !== 1'b1 || tx_ack !== 1'b0 || tx_busy !== 1'b0 || ps2clk_oe !== 1'b0 || ps2dat_oe !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_status: err=%b ack=%b busy=%b oe=%b%b expected 1/0/0/00",
                     tx_err, tx_ack, tx_busy, ps2clk_oe, ps2dat_oe);
        end
        @(negedge fpgaclk);
        vectors++;
        if (tx_done !== 1'b0 || tx_err !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_hold: done=%b err=%b expected 0/1", tx_done, tx_err);
        end
    endtask

    task automatic test_reset_mid_frame;
        logic busy_next, ack, err, busy, cloe, dtoe;
        logic [10:0] got;
        int inh_len, overlap;
        bit ok, seen;
        send_req(8'h96, busy_next);
        device_frame(1'b1, 5, got, inh_len, overlap, ok);
        #2 rst = 1'b0;
        #1;
        vectors++;
        if (ps2clk_oe !== 1'b0 || ps2dat_oe !== 1'b0 || tx_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: oe=%b%b busy=%b expected 00/0", ps2clk_oe, ps2dat_oe, tx_busy);
        end
        dev_clk = 1'b1;
        dev_dat = 1'b1;
        repeat (3) @(negedge fpgaclk);
        rst = 1'b1;
        repeat (5) @(negedge fpgaclk);
        send_req(8'hFF, busy_next);
        device_frame(1'b1, 11, got, inh_len, overlap, ok);
        wait_done(seen, ack, err, busy, cloe, dtoe);
        vectors++;
        if (!ok || got !== exp_frame(8'hFF) || !seen || ack !== 1'b1 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL after_reset_frame: bits=%b seen=%0d ack=%b err=%b expected %b/1/1/0",
                     got, seen, ack, err, exp_frame(8'hFF));
        end
    endtask

    initial begin
        test_reset();
        test_frames(6);
        test_busy_ignore();
        test_start_on_done();
        test_timeout();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter. It sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the FPGA to the keyboard over the same open-drain PS/2 clock/data pair that the receive path uses. It runs the full host request-to-send sequence: inhibit, start, 8 data bits, odd parity, stop, and device ACK. `tx_busy` lets the receive path ignore line activity while a transmission is in progress.

Parameters:
INHIBIT_CYCLES, 6000, fpgaclk cycles the clock line is held low before the start bit (120 us at 50 MHz).
TIMEOUT_CYCLES, 750000, max fpgaclk cycles allowed between consecutive device clock falling edges, or from clock release to first edge (15 ms at 50 MHz).

Ports:
fpgaclk  in  1  system clock, 50 MHz
rst  in  1  asynchronous, active-low reset
tx_data  in  8  byte to send, sampled on accepted tx_start
tx_start  in  1  one-cycle request; accepted only when tx_busy=0
tx_busy  out  1  high from the cycle after acceptance until tx_done
tx_done  out  1  one-cycle pulse at end of transfer (success or failure)
tx_ack  out  1  valid with tx_done: 1 = device ACK bit was 0
tx_err  out  1  valid with tx_done: 1 = timeout abort
ps2clk_in  in  1  raw PS/2 clock pin level
ps2dat_in  in  1  raw PS/2 data pin level
ps2clk_oe  out  1  1 = drive PS/2 clock low; 0 = release (pull-up)
ps2dat_oe  out  1  1 = drive PS/2 data low; 0 = release

Behaviour:
- Reset (async, rst=0):
  - state=IDLE; all outputs 0, so both lines are released immediately, even mid-transfer.
  - Counters cleared; synchronizers cleared to 1.
- Input conditioning:
  - ps2clk_in and ps2dat_in each pass through 2-flop synchronizers.
  - clk_fall = synced clock 1 -> 0, a single-cycle strobe.
  - Host updates ps2dat_oe within 3 fpgaclk cycles of a pin falling edge.
- Frame format:
  - Odd parity: par = ~^tx_data.
  - ps2dat_oe = ~bit for every bit driven (drive low for 0, release for 1).
- FSM:
  - IDLE: oe=0/0. On tx_start: latch tx_data, compute par, clear cnt, go to INHIBIT. tx_busy=1 from the next cycle.
  - INHIBIT: clk_oe=1, dat_oe=0; count INHIBIT_CYCLES. At terminal count, go to START.
  - START: clk_oe=1, dat_oe=1 (start bit 0) for exactly 1 cycle. Then go to SEND with bit_idx=0 and timer cleared.
  - SEND: clk_oe=0; dat_oe holds the current bit. On each clk_fall, bit_idx++ and the next bit is driven:
    - edges 1-8: d0..d7, LSB first
    - edge 9: parity
    - edge 10: stop (dat_oe=0)
    - After edge 10, go to ACK.
  - ACK: both released. On clk_fall (edge 11), capture ack = ~synced data, then go to WAIT_IDLE.
  - WAIT_IDLE: wait until synced clock=1 and data=1. Then pulse tx_done=1, tx_ack=ack, tx_err=0, and return to IDLE.
- tx_busy falls in the same cycle tx_done pulses. tx_ack and tx_err are held until the next accepted tx_start.
- Timeout:
  - In SEND, ACK and WAIT_IDLE a timer counts fpgaclk cycles and clears on every clk_fall.
  - If the timer reaches TIMEOUT_CYCLES: release both lines, pulse tx_done with tx_err=1 and tx_ack=0, go to IDLE.
- Protocol edge cases:
  - tx_start while tx_busy=1 is ignored; tx_data is not re-latched.
  - tx_start in the same cycle as tx_done is ignored; the requester retries after tx_busy is low.
  - Clock edges observed during INHIBIT or START are ignored.
  - No mid-frame abort input; only reset or timeout terminates a frame.
  - Device NACK (data high at edge 11): tx_done pulses with tx_ack=0, tx_err=0.
- Total frame: 11 device clock falling edges after clock release.

Test Plan:
- Send 0xED (INHIBIT_CYCLES=50, device model ~40-cycle half period, ACK low):
  - clk_oe low 50 cycles; dat_oe high before clk_oe drops.
  - Device samples start=0, bits 1,0,1,1,0,1,1,1, parity=1, stop=1.
  - tx_done=1, tx_ack=1, tx_err=0.
- Parity corners: 0x00 -> parity bit 1; 0x01 -> parity bit 0; 0xFF -> parity bit 1. Device model checks the whole frame.
- NACK: device leaves data high at edge 11 -> tx_done=1, tx_ack=0, tx_err=0; tx_busy low the same cycle.
- Timeout: TIMEOUT_CYCLES=1000, device never clocks -> tx_done and tx_err=1 exactly 1000 cycles after START exits; both oe=0.
- Busy ignore: tx_start with 0xF4 during a 0xED frame -> frame bits remain 0xED; no second frame starts.
- Reset mid-frame: rst=0 after edge 5 -> ps2clk_oe and ps2dat_oe 0 asynchronously, tx_busy=0; a new 0xFF transfer then completes normally.
